// File: rtl/reg_file_pkg.sv
// Shared constants and sizing helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;
  localparam int DEFAULT_NUM_REGS    = 8;

  // Address width needed to select one of 'depth' registers.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_entry.sv
// One register-file entry: a data word plus its pending (busy) flag.
module rf_entry #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we_sel,
  input  logic                   i_issue_sel,
  input  logic [WORD_LENGTH-1:0] i_wdata,
  output logic [WORD_LENGTH-1:0] o_data,
  output logic                   o_busy
);

  logic [WORD_LENGTH-1:0] r_data;
  logic                   r_busy;

  // Data word and busy flag; a same-cycle issue outranks the writeback release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= {WORD_LENGTH{1'b0}};
      r_busy <= 1'b0;
    end else begin
      if (i_we_sel) begin
        r_data <= i_wdata;
      end else begin
        r_data <= r_data;
      end
      if (i_issue_sel) begin
        r_busy <= 1'b1;
      end else if (i_we_sel) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two bypassed combinational read ports and a per-register
// busy scoreboard for the multicycle datapath.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter  int NUM_REGS    = DEFAULT_NUM_REGS,
  parameter  int ZERO_REG    = 1,
  localparam int ADDR_W      = addr_w(NUM_REGS),
  localparam int CNT_W       = $clog2(NUM_REGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [WORD_LENGTH-1:0] wdata,
  input  logic                   issue,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [WORD_LENGTH-1:0] rdata1,
  output logic [WORD_LENGTH-1:0] rdata2,
  output logic                   rbusy1,
  output logic                   rbusy2,
  output logic [CNT_W-1:0]       busy_count
);

  logic [WORD_LENGTH-1:0] w_data [NUM_REGS];
  logic [NUM_REGS-1:0]    w_busy;
  logic [NUM_REGS-1:0]    w_busy_next;
  logic [CNT_W-1:0]       w_count_next;
  logic [CNT_W-1:0]       r_busy_count;
  logic                   w_byp1;
  logic                   w_byp2;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      assign w_data[gi] = {WORD_LENGTH{1'b0}};
      assign w_busy[gi] = 1'b0;
    end else begin : g_reg
      logic w_we_sel;
      logic w_issue_sel;
      assign w_we_sel    = we && (waddr == ADDR_W'(gi));
      assign w_issue_sel = issue && (issue_addr == ADDR_W'(gi));
      rf_entry #(.WORD_LENGTH(WORD_LENGTH)) u_entry (
        .clk        (clk),
        .rst        (rst),
        .i_we_sel   (w_we_sel),
        .i_issue_sel(w_issue_sel),
        .i_wdata    (wdata),
        .o_data     (w_data[gi]),
        .o_busy     (w_busy[gi])
      );
    end
  end

  // Predicted busy vector after this edge, mirroring the entry priority.
  always_comb begin
    w_busy_next = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ZERO_REG != 0 && i == 0) begin
        w_busy_next[i] = 1'b0;
      end else if (issue && (issue_addr == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (we && (waddr == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b0;
      end else begin
        w_busy_next[i] = w_busy[i];
      end
    end
  end

  // Population count of the next busy vector.
  always_comb begin
    w_count_next = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      w_count_next = w_count_next + CNT_W'(w_busy_next[i]);
    end
  end

  // Busy count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_count <= {CNT_W{1'b0}};
    end else begin
      r_busy_count <= w_count_next;
    end
  end

  assign busy_count = r_busy_count;

  // Writeback bypass never applies to the hardwired zero register.
  assign w_byp1 = we && (waddr == raddr1) &&
                  !(ZERO_REG != 0 && raddr1 == {ADDR_W{1'b0}});
  assign w_byp2 = we && (waddr == raddr2) &&
                  !(ZERO_REG != 0 && raddr2 == {ADDR_W{1'b0}});

  // Read ports: bypassed write data, else the stored word.
  always_comb begin
    rdata1 = {WORD_LENGTH{1'b0}};
    rdata2 = {WORD_LENGTH{1'b0}};
    if (w_byp1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = w_data[raddr1];
    end
    if (w_byp2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = w_data[raddr2];
    end
  end

  assign rbusy1 = w_busy[raddr1] && !(we && (waddr == raddr1));
  assign rbusy2 = w_busy[raddr2] && !(we && (waddr == raddr2));

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        issue;
  logic [2:0]  issue_addr;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic        rbusy1;
  logic        rbusy2;
  logic [3:0]  busy_count;

  typedef struct packed {
    logic [4:0]  mask;   // {cnt, b2, b1, rd2, rd1}
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        b1;
    logic        b2;
    logic [3:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  bit    stim_done = 1'b0;

  reg_file_sb #(.WORD_LENGTH(16), .NUM_REGS(8), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .issue(issue), .issue_addr(issue_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic r, input logic w, input logic [2:0] wa,
                     input logic [15:0] wd, input logic is, input logic [2:0] ia,
                     input logic [2:0] a1, input logic [2:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    issue = is; issue_addr = ia; raddr1 = a1; raddr2 = a2;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] m,
                            input logic [15:0] e1, input logic [15:0] e2,
                            input logic eb1, input logic eb2, input logic [3:0] ec);
    exp_t e;
    e.mask = m; e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2; e.cnt = ec;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare one queued expectation per cycle, then summarise.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.mask[0]) begin
          total++;
          if (rdata1 !== e.rd1) begin
            bad++; $display("FAIL %s rdata1 actual=%h required=%h", nm, rdata1, e.rd1);
          end
        end
        if (e.mask[1]) begin
          total++;
          if (rdata2 !== e.rd2) begin
            bad++; $display("FAIL %s rdata2 actual=%h required=%h", nm, rdata2, e.rd2);
          end
        end
        if (e.mask[2]) begin
          total++;
          if (rbusy1 !== e.b1) begin
            bad++; $display("FAIL %s rbusy1 actual=%b required=%b", nm, rbusy1, e.b1);
          end
        end
        if (e.mask[3]) begin
          total++;
          if (rbusy2 !== e.b2) begin
            bad++; $display("FAIL %s rbusy2 actual=%b required=%b", nm, rbusy2, e.b2);
          end
        end
        if (e.mask[4]) begin
          total++;
          if (busy_count !== e.cnt) begin
            bad++; $display("FAIL %s busy_count actual=%0d required=%0d", nm, busy_count, e.cnt);
          end
        end
      end else if (stim_done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Watchdog in case the run never drains.
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus; state comments give the busy set after each edge.
  initial begin
    drv(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd7);
    expect_out("reset_read", 5'b11111, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd5, 3'd3);
    expect_out("bypass_write5", 5'b11111, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd5);
    expect_out("stored_read5_both", 5'b11111, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 3'd0, 3'd5);
    expect_out("zero_reg_bypass", 5'b10111, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd5);
    expect_out("zero_reg_after", 5'b10101, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd4);
    expect_out("issue2_same_cycle", 5'b11100, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick(); // busy {2}
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd2, 3'd4);
    expect_out("issue4", 5'b11100, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'd1);
    tick(); // busy {2,4}
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd4);
    expect_out("reissue2", 5'b11100, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd2);
    tick(); // busy {2,4}
    drv(1'b0, 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 3'd2, 3'd4);
    expect_out("writeback2", 5'b11101, 16'h00AA, 16'h0000, 1'b0, 1'b1, 4'd2);
    tick(); // busy {4}
    drv(1'b0, 1'b1, 3'd3, 16'h0033, 1'b0, 3'd0, 3'd2, 3'd3);
    expect_out("after_wb2_write3", 5'b11111, 16'h00AA, 16'h0033, 1'b0, 1'b0, 4'd1);
    tick(); // busy {4}
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd3, 3'd4);
    expect_out("nonbusy_write_cnt", 5'b11101, 16'h0033, 16'h0000, 1'b0, 1'b1, 4'd1);
    tick(); // busy {4,6}
    drv(1'b0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 3'd6, 3'd4);
    expect_out("we_issue_same6", 5'b11101, 16'h6666, 16'h0000, 1'b0, 1'b1, 4'd2);
    tick(); // busy {4,6}
    drv(1'b0, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 3'd6, 3'd4);
    expect_out("we4_issue1", 5'b11111, 16'h6666, 16'h4444, 1'b1, 1'b0, 4'd2);
    tick(); // busy {1,6}
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd1, 3'd4);
    expect_out("after_we4_issue1", 5'b11111, 16'h0000, 16'h4444, 1'b1, 1'b0, 4'd2);
    tick(); // busy {1,6,7}
    drv(1'b1, 1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd3, 3'd7, 3'd6);
    expect_out("pre_reset_three_busy", 5'b11111, 16'h0000, 16'h6666, 1'b1, 1'b1, 4'd3);
    tick(); // reset
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd6);
    expect_out("post_reset", 5'b11111, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 3'd7, 3'd2);
    expect_out("write7_after_reset", 5'b11111, 16'h7777, 16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    drv(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd7, 3'd7);
    expect_out("read7_after_reset", 5'b11111, 16'h7777, 16'h7777, 1'b0, 1'b0, 4'd0);
    tick();
    stim_done = 1'b1;
  end

endmodule
